// File: rtl/clb_output_stage.sv
// CLB output stage: per-output sum/LUT select, optional data flops and Co flop, all driven by a serial config chain.
// Combinational paths 0 cycles, registered paths 1 cycle; no flow control, flops update only on a completed, idle config.
module clb_output_stage #(
  parameter int OUTPUTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OUTPUTS-1:0] sum,
  input  logic               co,
  input  logic [OUTPUTS-1:0] lut_out,
  input  logic               ce,
  input  logic               sr,
  input  logic               cfg_en,
  input  logic               cfg_in,
  output logic               cfg_out,
  output logic               cfg_done,
  output logic [OUTPUTS-1:0] out,
  output logic               co_out
);

  localparam int CFG_BITS = 3*OUTPUTS + 1;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_BITS-1:0] cfg;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                done_q;

  logic [OUTPUTS-1:0]  sel_sum;
  logic [OUTPUTS-1:0]  sel_reg;
  logic [OUTPUTS-1:0]  init;
  logic                co_reg;

  logic [OUTPUTS-1:0]  d;
  logic [OUTPUTS-1:0]  q;
  logic                qco;
  logic                upd;

  assign sel_sum = cfg[OUTPUTS-1:0];
  assign sel_reg = cfg[2*OUTPUTS-1:OUTPUTS];
  assign init    = cfg[3*OUTPUTS-1:2*OUTPUTS];
  assign co_reg  = cfg[3*OUTPUTS];

  // A shift past a complete load starts the next load at count 1.
  always_comb begin
    cnt_nxt = cnt;
    if (cfg_en) begin
      if (cnt == CNT_FULL) begin
        cnt_nxt = CNT_ONE;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      if (cfg_en) begin
        cfg <= {cfg[CFG_BITS-2:0], cfg_in};
      end
      cnt    <= cnt_nxt;
      done_q <= (cnt_nxt == CNT_FULL);
    end
  end

  assign cfg_out  = cfg[CFG_BITS-1];
  assign cfg_done = done_q;

  assign d   = (sel_sum & sum) | (~sel_sum & lut_out);
  assign upd = done_q && !cfg_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      qco <= 1'b0;
    end else if (upd) begin
      if (sr) begin
        q   <= init;
        qco <= 1'b0;
      end else if (ce) begin
        q   <= d;
        qco <= co;
      end
    end
  end

  assign out    = (sel_reg & q) | (~sel_reg & d);
  assign co_out = co_reg ? qco : co;

endmodule

// File: tb/tb_clb_output_stage.sv
// Bench for clb_output_stage: directed scenarios plus randomized traffic against a shift-history reference model.
module tb_clb_output_stage;
  localparam int N  = 4;
  localparam int CB = 3*N + 1;

  logic clk = 1'b0;
  logic rst, ce, sr, cfg_en, cfg_in, co;
  logic [N-1:0] sum, lut_out;
  logic [N-1:0] out, out2;
  logic cfg_out, cfg_done, co_out;
  logic cfg_out2, cfg_done2, co_out2;

  int checks = 0;
  int failures = 0;

  // Model state: every bit ever shifted since reset, plus the data flops.
  bit hist[$];
  int n_shift = 0;
  logic [N-1:0] m_q = '0;
  logic m_qco = 1'b0;

  always #5 clk = ~clk;

  clb_output_stage #(.OUTPUTS(N)) u_dut (
    .clk(clk), .rst(rst), .sum(sum), .co(co), .lut_out(lut_out),
    .ce(ce), .sr(sr), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out), .cfg_done(cfg_done), .out(out), .co_out(co_out)
  );

  clb_output_stage #(.OUTPUTS(N)) u_dn (
    .clk(clk), .rst(rst), .sum(sum), .co(co), .lut_out(lut_out),
    .ce(ce), .sr(sr), .cfg_en(cfg_en), .cfg_in(cfg_out),
    .cfg_out(cfg_out2), .cfg_done(cfg_done2), .out(out2), .co_out(co_out2)
  );

  function automatic logic [CB-1:0] mcfg();
    logic [CB-1:0] c;
    c = '0;
    for (int k = 0; k < CB; k++)
      if (k < hist.size()) c[k] = hist[hist.size()-1-k];
    return c;
  endfunction

  function automatic logic exp_done();
    return (n_shift > 0) && (n_shift % CB == 0);
  endfunction

  function automatic logic [N-1:0] dvec(logic [CB-1:0] c, logic [N-1:0] s, logic [N-1:0] l);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = c[i] ? s[i] : l[i];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_out(logic [CB-1:0] c, logic [N-1:0] q, logic [N-1:0] s, logic [N-1:0] l);
    logic [N-1:0] dd, r;
    dd = dvec(c, s, l);
    for (int i = 0; i < N; i++) r[i] = c[N+i] ? q[i] : dd[i];
    return r;
  endfunction

  function automatic logic exp_co(logic [CB-1:0] c, logic qc, logic cc);
    return c[3*N] ? qc : cc;
  endfunction

  // Advance the model with the current inputs, then take one clock edge.
  task automatic step();
    logic [CB-1:0] c;
    logic done;
    c = mcfg();
    done = exp_done();
    if (rst) begin
      hist.delete();
      n_shift = 0;
      m_q = '0;
      m_qco = 1'b0;
    end else begin
      if (done && !cfg_en) begin
        if (sr) begin
          m_q = c[3*N-1:2*N];
          m_qco = 1'b0;
        end else if (ce) begin
          m_q = dvec(c, sum, lut_out);
          m_qco = co;
        end
      end
      if (cfg_en) begin
        hist.push_back(cfg_in);
        n_shift++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [CB-1:0] w);
    for (int b = CB-1; b >= 0; b--) begin
      cfg_en = 1'b1;
      cfg_in = w[b];
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; sr = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    lut_out = 4'b1010; sum = 4'b0101; co = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out !== 4'b1010) begin failures++; $display("FAIL reset_out got=%b want=%b", out, 4'b1010); end
    checks++; if (co_out !== 1'b1) begin failures++; $display("FAIL reset_co_out got=%b want=1", co_out); end
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL reset_cfg_done got=%b want=0", cfg_done); end
    checks++; if (cfg_out !== 1'b0) begin failures++; $display("FAIL reset_cfg_out got=%b want=0", cfg_out); end
  endtask

  task automatic test_load_sum();
    logic [CB-1:0] w;
    w = 13'h1_0FF;
    for (int b = CB-1; b >= 0; b--) begin
      if (b == 0) begin
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL load_done_early got=%b want=0", cfg_done); end
      end
      cfg_en = 1'b1;
      cfg_in = w[b];
      step();
    end
    cfg_en = 1'b0;
    checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL load_done got=%b want=1", cfg_done); end
    checks++; if (cfg_out !== 1'b1) begin failures++; $display("FAIL load_cfg_out got=%b want=1", cfg_out); end
    sum = 4'b0110; lut_out = 4'b1001; co = 1'b1; ce = 1'b1;
    step();
    ce = 1'b0; sum = 4'b0000; co = 1'b0;
    #1;
    checks++; if (out !== 4'b0110) begin failures++; $display("FAIL load_reg_out got=%b want=%b", out, 4'b0110); end
    checks++; if (co_out !== 1'b1) begin failures++; $display("FAIL load_reg_co got=%b want=1", co_out); end
  endtask

  task automatic test_sr_priority();
    shift_word(13'h1_FFF);
    checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL sr_done got=%b want=1", cfg_done); end
    sum = 4'b0000; co = 1'b1; sr = 1'b1; ce = 1'b1;
    step();
    sr = 1'b0; ce = 1'b0;
    #1;
    checks++; if (out !== 4'b1111) begin failures++; $display("FAIL sr_out got=%b want=%b", out, 4'b1111); end
    checks++; if (co_out !== 1'b0) begin failures++; $display("FAIL sr_co got=%b want=0", co_out); end
  endtask

  task automatic test_extra_shift();
    cfg_en = 1'b1; cfg_in = 1'b0;
    step();
    cfg_en = 1'b0;
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL extra_done got=%b want=0", cfg_done); end
    checks++; if (cfg_out !== 1'b1) begin failures++; $display("FAIL extra_cfg_out got=%b want=1", cfg_out); end
    for (int k = 0; k < 3; k++) begin
      ce = 1'b1; sum = 4'b0000; lut_out = 4'b0000; co = 1'b1;
      step();
    end
    ce = 1'b0;
    #1;
    checks++; if (out !== 4'b1111) begin failures++; $display("FAIL extra_hold_out got=%b want=%b", out, 4'b1111); end
    checks++; if (co_out !== 1'b0) begin failures++; $display("FAIL extra_hold_co got=%b want=0", co_out); end
  endtask

  task automatic test_reset_midload();
    for (int k = 0; k < 7; k++) begin
      cfg_en = 1'b1; cfg_in = 1'b1;
      step();
    end
    cfg_en = 1'b0;
    lut_out = 4'($urandom); sum = 4'($urandom); co = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b want=0", cfg_done); end
    checks++; if (cfg_out !== 1'b0) begin failures++; $display("FAIL mid_cfg_out got=%b want=0", cfg_out); end
    checks++; if (out !== lut_out) begin failures++; $display("FAIL mid_out got=%b want=%b", out, lut_out); end
    shift_word(13'($urandom));
    #1;
    checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL mid_reload_done got=%b want=1", cfg_done); end
    checks++; if (out !== exp_out(mcfg(), m_q, sum, lut_out)) begin failures++; $display("FAIL mid_reload_out got=%b want=%b", out, exp_out(mcfg(), m_q, sum, lut_out)); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      rst = 1'b0; ce = 1'b0; sr = 1'b0;
      shift_word(13'($urandom));
      for (int c = 0; c < 30; c++) begin
        cfg_en = ($urandom_range(15) == 0);
        cfg_in = 1'($urandom);
        ce = 1'($urandom);
        sr = ($urandom_range(3) == 0);
        rst = ($urandom_range(79) == 0);
        sum = 4'($urandom); lut_out = 4'($urandom); co = 1'($urandom);
        #1;
        checks++; if (out !== exp_out(mcfg(), m_q, sum, lut_out)) begin failures++; $display("FAIL rand_out r=%0d c=%0d got=%b want=%b", r, c, out, exp_out(mcfg(), m_q, sum, lut_out)); end
        checks++; if (co_out !== exp_co(mcfg(), m_qco, co)) begin failures++; $display("FAIL rand_co r=%0d c=%0d got=%b want=%b", r, c, co_out, exp_co(mcfg(), m_qco, co)); end
        checks++; if (cfg_done !== exp_done()) begin failures++; $display("FAIL rand_done r=%0d c=%0d got=%b want=%b", r, c, cfg_done, exp_done()); end
        checks++; if (cfg_out !== mcfg()[CB-1]) begin failures++; $display("FAIL rand_cfg_out r=%0d c=%0d got=%b want=%b", r, c, cfg_out, mcfg()[CB-1]); end
        step();
      end
    end
    rst = 1'b0; cfg_en = 1'b0; ce = 1'b0; sr = 1'b0;
  endtask

  task automatic test_chain();
    logic [CB-1:0] w1, w2;
    w1 = 13'($urandom);
    w2 = 13'($urandom);
    rst = 1'b1;
    step();
    rst = 1'b0;
    shift_word(w1);
    shift_word(w2);
    sum = 4'($urandom); lut_out = 4'($urandom); co = 1'b1;
    #1;
    checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL chain_up_done got=%b want=1", cfg_done); end
    checks++; if (cfg_done2 !== 1'b1) begin failures++; $display("FAIL chain_dn_done got=%b want=1", cfg_done2); end
    checks++; if (cfg_out2 !== w1[CB-1]) begin failures++; $display("FAIL chain_dn_cfg_out got=%b want=%b", cfg_out2, w1[CB-1]); end
    checks++; if (out2 !== exp_out(w1, 4'b0000, sum, lut_out)) begin failures++; $display("FAIL chain_dn_out got=%b want=%b", out2, exp_out(w1, 4'b0000, sum, lut_out)); end
    checks++; if (co_out2 !== exp_co(w1, 1'b0, co)) begin failures++; $display("FAIL chain_dn_co got=%b want=%b", co_out2, exp_co(w1, 1'b0, co)); end
    checks++; if (out !== exp_out(w2, 4'b0000, sum, lut_out)) begin failures++; $display("FAIL chain_up_out got=%b want=%b", out, exp_out(w2, 4'b0000, sum, lut_out)); end
    checks++; if (cfg_out !== w2[CB-1]) begin failures++; $display("FAIL chain_up_cfg_out got=%b want=%b", cfg_out, w2[CB-1]); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; sr = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    co = 1'b0; sum = '0; lut_out = '0;
    test_reset();
    test_load_sum();
    test_sr_priority();
    test_extra_shift();
    test_reset_midload();
    test_random();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
